frame_histogram_cdf: RTL and testbench
======================================

# frame_histogram_cdf

Parametrised frame-statistics engine for the grayscale video path. Builds a per-frame histogram from a pixel stream, derives the cumulative histogram and a percentile threshold, and publishes the result through ping-pong banks. The next frame can be accumulated while the previous frame's results stay readable. Sits after the gray conversion stage and feeds the binarisation stage and the display overlay.

## Interface
Parameters:
- PIX_W, 8, pixel bit width; bin count NB = 2^PIX_W
- CNT_W, 20, per-bin and total counter width

Ports:
- iClk  in  1  clock
- iRst_n  in  1  reset, asynchronous, active-low
- iGray  in  PIX_W  pixel value
- iGrayValid  in  1  pixel qualifier; ignored unless accumulating
- iFvalid  in  1  frame valid; rising edge starts a frame, falling edge ends it
- iPercent  in  7  threshold percentile 0..100; values >100 clamp to 100; sampled on the iFvalid rising edge
- iReadGray  in  PIX_W  read address into the published bank
- oGrayHisto  out  CNT_W  histogram[iReadGray] of the published frame
- oGrayCumHisto  out  CNT_W  cumulative[iReadGray] of the published frame
- oTotal  out  CNT_W  pixel count of the published frame
- oThresh  out  PIX_W  threshold of the published frame
- oValid  out  1  high once at least one frame has been published
- oDone  out  1  one-cycle pulse when a frame is published
- oDropped  out  1  one-cycle pulse when a frame start is ignored
- oBusy  out  1  high in every state except IDLE

## Operation
- Two banks (A and B), each holding a histogram RAM and a cumulative RAM of NB×CNT_W. Work bank = !pub. Published bank = pub; pub resets to B.
- FSM states:
  - CLEAR: writes 0 to every work-bank histogram bin, NB cycles, then goes to IDLE. This state is also entered straight out of reset.
  - IDLE: waits for an iFvalid rising edge. On the edge, latches the clamped iPercent, zeroes the total, and goes to ACCUM.
  - ACCUM: each iGrayValid cycle increments bin[iGray] and the total. The iFvalid falling edge goes to DRAIN.
  - DRAIN: waits until the RMW pipeline is empty (at most 3 cycles), then goes to CUM.
  - CUM: sweeps g = 0..NB-1, keeping a running sum. Writes cum[g] into the work bank. The threshold is the first g with cum[g]·100 ≥ total·pct, compared at CNT_W+7 bits. After the last write: pub flips, oDone pulses, oThresh and oTotal update, oValid goes to 1, then the FSM goes to CLEAR.
- Increment RMW pipeline: read, then +1, then write. Back-to-back or 1-apart pixels with the same value must forward the in-flight count; no increment may be lost.
- Bin and total counters saturate at 2^CNT_W−1.
- Rising iFvalid seen in CLEAR, DRAIN or CUM: the whole frame is ignored and oDropped pulses once. Pixels of that frame are discarded.
- Frame with zero valid pixels: all bins 0, threshold 0.
- pct = 0 gives threshold 0. pct = 100 gives the first bin whose cumulative count equals the total.
- Async reset clears the FSM to CLEAR, sets pub = B, and clears oValid, oDone, oDropped, oThresh and oTotal. RAM contents are undefined until rewritten.
- When oValid = 0, read outputs are 0.

## Timing
- Read latency: iReadGray is registered, then the RAM read, then the output register, so data for an address appears 3 cycles after it.
- When the bank flips, reads issued before the flip return old-bank data.
- Reset values: oGrayHisto = 0, oGrayCumHisto = 0, oTotal = 0, oThresh = 0, oValid = 0, oDone = 0, oDropped = 0, oBusy = 1 (CLEAR).
- Pixel input accepts one pixel per cycle, sustained, with no back-pressure.
- Frame end to oDone: ≤ 3 (DRAIN) + NB + 2 cycles.
- The FSM returns to IDLE NB cycles after oDone. Minimum vertical blank for no drops is 2·NB + 5 cycles.

## Test plan
- Reset, then a frame of 16 pixels all of value 5, pct = 50 → oDone once; hist[5] = 16, others 0; cum[4] = 0, cum[5] = 16; oThresh = 5; oTotal = 16; oValid = 1.
- Back-to-back pixels 7,7,7,8,7 plus a 1-gap repeat → hist[7] = 4, hist[8] = 1; proves forwarding.
- Ramp 0..255, one pixel each, pct = 25 → cum[g] = g+1, oThresh = 63; pct = 100 → oThresh = 255.
- Second iFvalid rise 10 cycles after the first frame ends → oDropped pulses; published data unchanged; the third frame is accepted normally.
- PIX_W = 4, CNT_W = 4, 20 pixels of value 3 → hist[3] = 15 (saturated), oTotal = 15.
- Assert iRst_n low mid-ACCUM → oValid = 0, outputs 0, FSM in CLEAR; the next full frame publishes correctly.

Source files
------------

// File: rtl/frame_histogram_cdf.sv
// Per-frame grayscale histogram, cumulative histogram and percentile threshold,
// published through ping-pong banks so the next frame accumulates while the last stays readable.
module frame_histogram_cdf #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [PIX_W-1:0] iGray,
  input  logic             iGrayValid,
  input  logic             iFvalid,
  input  logic [6:0]       iPercent,
  input  logic [PIX_W-1:0] iReadGray,
  output logic [CNT_W-1:0] oGrayHisto,
  output logic [CNT_W-1:0] oGrayCumHisto,
  output logic [CNT_W-1:0] oTotal,
  output logic [PIX_W-1:0] oThresh,
  output logic             oValid,
  output logic             oDone,
  output logic             oDropped,
  output logic             oBusy
);
  localparam int NB = 1 << PIX_W;
  localparam int CW = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PIX_W-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {CLEAR, IDLE, ACCUM, DRAIN, CUM} stateE;

  stateE            state, stateNext;
  logic             fvalidQ, frameRise, frameFall;
  logic             pub, work;
  logic [PIX_W-1:0] idx, rdSel;
  logic [6:0]       pct;
  logic [CNT_W-1:0] total;

  logic             v1, v2, v3;
  logic [PIX_W-1:0] a1, a2, a3;
  logic [CNT_W-1:0] w3, wrkRd, incBase, incVal;

  logic             cumV, found, hit, lastBin;
  logic [PIX_W-1:0] cumG, thrIdx, thrNext;
  logic [CNT_W-1:0] runSum, cumSum;
  logic [CW-1:0]    lhs, rhs;

  logic             rdBank;
  logic [PIX_W-1:0] rdAddr;
  logic [CNT_W-1:0] pubHist, pubCum;

  logic [CNT_W-1:0] histMem [2][NB];
  logic [CNT_W-1:0] cumMem  [2][NB];

  assign work      = ~pub;
  assign frameRise = iFvalid & ~fvalidQ;
  assign frameFall = ~iFvalid & fvalidQ;
  assign lastBin   = cumV && (cumG == LAST_BIN);
  assign oBusy     = (state != IDLE);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= CLEAR;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      CLEAR:   if (idx == LAST_BIN) stateNext = IDLE;
      IDLE:    if (frameRise)       stateNext = ACCUM;
      ACCUM:   if (frameFall)       stateNext = DRAIN;
      DRAIN:   if (!v1 && !v2)      stateNext = CUM;
      CUM:     if (lastBin)         stateNext = CLEAR;
      default:                      stateNext = CLEAR;
    endcase
  end

  // Increment forwarding: the entry in w3 was written on the same edge this bin was read.
  always_comb begin
    incBase = (v3 && (a3 == a2)) ? w3 : wrkRd;
    incVal  = (incBase == CNT_MAX) ? incBase : incBase + CNT_W'(1);
    cumSum  = (runSum > CNT_MAX - wrkRd) ? CNT_MAX : runSum + wrkRd;
    lhs     = CW'(cumSum) * CW'(100);
    rhs     = CW'(total) * CW'(pct);
    hit     = (lhs >= rhs);
    thrNext = found ? thrIdx : (hit ? cumG : LAST_BIN);
    rdSel   = (state == CUM) ? idx : a1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fvalidQ  <= 1'b0;
      idx      <= '0;
      pct      <= '0;
      total    <= '0;
      pub      <= 1'b1;
      oDone    <= 1'b0;
      oDropped <= 1'b0;
      oValid   <= 1'b0;
      oThresh  <= '0;
      oTotal   <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      a1 <= '0;   a2 <= '0;   a3 <= '0;
      w3       <= '0;
      cumV     <= 1'b0;
      cumG     <= '0;
      runSum   <= '0;
      found    <= 1'b0;
      thrIdx   <= '0;
      rdAddr   <= '0;
      rdBank   <= 1'b1;
      oGrayHisto    <= '0;
      oGrayCumHisto <= '0;
    end else begin
      fvalidQ  <= iFvalid;
      idx      <= (stateNext != state) ? '0 : idx + PIX_W'(1);
      oDropped <= frameRise && (state == CLEAR || state == DRAIN || state == CUM);
      oDone    <= lastBin;

      if (state == IDLE && frameRise) begin
        pct   <= (iPercent > 7'd100) ? 7'd100 : iPercent;
        total <= '0;
      end else if (state == ACCUM && iGrayValid && total != CNT_MAX) begin
        total <= total + CNT_W'(1);
      end

      v1 <= (state == ACCUM) && iGrayValid;
      a1 <= iGray;
      v2 <= v1;  a2 <= a1;
      v3 <= v2;  a3 <= a2;
      w3 <= incVal;

      cumV <= (state == CUM) && !lastBin;
      cumG <= idx;
      if (state != CUM) begin
        runSum <= '0;
        found  <= 1'b0;
        thrIdx <= '0;
      end else if (cumV) begin
        runSum <= cumSum;
        if (!found && hit) begin
          found  <= 1'b1;
          thrIdx <= cumG;
        end
      end

      if (lastBin) begin
        pub     <= ~pub;
        oThresh <= thrNext;
        oTotal  <= total;
        oValid  <= 1'b1;
      end

      // Bank travels with the address so reads issued before a flip see the old bank.
      rdAddr        <= iReadGray;
      rdBank        <= pub;
      oGrayHisto    <= oValid ? pubHist : '0;
      oGrayCumHisto <= oValid ? pubCum  : '0;
    end
  end

  // NOTE: RAM arrays carry no reset; every work-bank bin is rewritten before it is published.
  always_ff @(posedge iClk) begin
    wrkRd <= histMem[work][rdSel];
    if (state == CLEAR)  histMem[work][idx] <= '0;
    else if (v2)         histMem[work][a2]  <= incVal;
    if (cumV)            cumMem[work][cumG] <= cumSum;
    pubHist <= histMem[rdBank][rdAddr];
    pubCum  <= cumMem[rdBank][rdAddr];
  end

endmodule

// File: tb/tb_frame_histogram_cdf.sv
// Directed self-checking bench for frame_histogram_cdf: default 8-bit instance
// plus a 4-bit/4-bit instance for counter saturation.
module tb_frame_histogram_cdf;
  localparam int NB = 256;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [7:0]  iGray = '0;
  logic        iGrayValid = 1'b0;
  logic        iFvalid = 1'b0;
  logic [6:0]  iPercent = '0;
  logic [7:0]  iReadGray = '0;
  logic [19:0] oGrayHisto, oGrayCumHisto, oTotal;
  logic [7:0]  oThresh;
  logic        oValid, oDone, oDropped, oBusy;

  logic [3:0]  sGray = '0;
  logic        sGrayValid = 1'b0;
  logic        sFvalid = 1'b0;
  logic [6:0]  sPercent = '0;
  logic [3:0]  sReadGray = '0;
  logic [3:0]  sHisto, sCumHisto, sTotal, sThresh;
  logic        sValid, sDone, sDropped, sBusy;

  int asserts = 0;
  int failures = 0;
  int doneCnt = 0;
  int dropCnt = 0;
  int pixQ[$];

  frame_histogram_cdf dut (
    .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iGrayValid(iGrayValid),
    .iFvalid(iFvalid), .iPercent(iPercent), .iReadGray(iReadGray),
    .oGrayHisto(oGrayHisto), .oGrayCumHisto(oGrayCumHisto), .oTotal(oTotal),
    .oThresh(oThresh), .oValid(oValid), .oDone(oDone), .oDropped(oDropped), .oBusy(oBusy)
  );

  frame_histogram_cdf #(.PIX_W(4), .CNT_W(4)) dutS (
    .iClk(iClk), .iRst_n(iRst_n), .iGray(sGray), .iGrayValid(sGrayValid),
    .iFvalid(sFvalid), .iPercent(sPercent), .iReadGray(sReadGray),
    .oGrayHisto(sHisto), .oGrayCumHisto(sCumHisto), .oTotal(sTotal),
    .oThresh(sThresh), .oValid(sValid), .oDone(sDone), .oDropped(sDropped), .oBusy(sBusy)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oDone === 1'b1)    doneCnt++;
    if (oDropped === 1'b1) dropCnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic readBin(input int g, output logic [19:0] h, output logic [19:0] c);
    @(negedge iClk);
    iReadGray = 8'(g);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    h = oGrayHisto;
    c = oGrayCumHisto;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (oBusy && n < 2000) begin
      @(negedge iClk);
      n++;
    end
    asserts++;
    if (oBusy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_wait: busy=%0b expected 0", tag, oBusy);
    end
  endtask

  task automatic waitDone(input int start, input string tag);
    int n = 0;
    while (doneCnt == start && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    asserts++;
    if (doneCnt == start) begin
      failures++;
      $display("FAIL %s done_wait: no oDone within %0d cycles, expected one", tag, n);
    end
  endtask

  task automatic sendFrame(input int pct);
    @(negedge iClk);
    iPercent = 7'(pct);
    iFvalid  = 1'b1;
    foreach (pixQ[i]) begin
      @(negedge iClk);
      if (pixQ[i] < 0) iGrayValid = 1'b0;
      else begin
        iGray      = 8'(pixQ[i]);
        iGrayValid = 1'b1;
      end
    end
    @(negedge iClk);
    iGrayValid = 1'b0;
    @(negedge iClk);
    iFvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge iClk);
    asserts++;
    if ({oGrayHisto, oGrayCumHisto, oTotal, oThresh} !== 68'd0) begin
      failures++;
      $display("FAIL reset_data: got h=%0d c=%0d tot=%0d thr=%0d expected all 0",
               oGrayHisto, oGrayCumHisto, oTotal, oThresh);
    end
    asserts++;
    if ({oValid, oDone, oDropped, oBusy} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags: got valid/done/drop/busy=%b expected 0001",
               {oValid, oDone, oDropped, oBusy});
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    waitIdle("reset");
    asserts++;
    if (oValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_novalid: oValid=%0b expected 0", oValid);
    end
  endtask

  task automatic test_single_value();
    int g[5]  = '{0, 4, 5, 6, 255};
    int eh[5] = '{0, 0, 16, 0, 0};
    int ec[5] = '{0, 0, 16, 16, 16};
    logic [19:0] h, c;
    int start = doneCnt;
    pixQ = {};
    repeat (16) pixQ.push_back(5);
    sendFrame(50);
    waitDone(start, "single");
    @(negedge iClk);
    asserts++;
    if (oThresh !== 8'd5) begin failures++; $display("FAIL single_thresh: got %0d expected 5", oThresh); end
    asserts++;
    if (oTotal !== 20'd16) begin failures++; $display("FAIL single_total: got %0d expected 16", oTotal); end
    asserts++;
    if (oValid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b expected 1", oValid); end
    for (int i = 0; i < 5; i++) begin
      readBin(g[i], h, c);
      asserts++;
      if (h !== 20'(eh[i])) begin failures++; $display("FAIL single_hist[%0d]: got %0d expected %0d", g[i], h, eh[i]); end
      asserts++;
      if (c !== 20'(ec[i])) begin failures++; $display("FAIL single_cum[%0d]: got %0d expected %0d", g[i], c, ec[i]); end
    end
    waitIdle("single");
    asserts++;
    if (doneCnt - start !== 1) begin failures++; $display("FAIL single_done_count: got %0d expected 1", doneCnt - start); end
  endtask

  task automatic test_back_to_back();
    int g[4]  = '{6, 7, 8, 9};
    int eh[4] = '{0, 4, 1, 0};
    int ec[4] = '{0, 4, 5, 5};
    logic [19:0] h, c;
    int start = doneCnt;
    pixQ = '{7, 7, -1, 7, 8, 7};
    sendFrame(50);
    waitDone(start, "b2b");
    @(negedge iClk);
    asserts++;
    if (oTotal !== 20'd5) begin failures++; $display("FAIL b2b_total: got %0d expected 5", oTotal); end
    asserts++;
    if (oThresh !== 8'd7) begin failures++; $display("FAIL b2b_thresh: got %0d expected 7", oThresh); end
    for (int i = 0; i < 4; i++) begin
      readBin(g[i], h, c);
      asserts++;
      if (h !== 20'(eh[i])) begin failures++; $display("FAIL b2b_hist[%0d]: got %0d expected %0d", g[i], h, eh[i]); end
      asserts++;
      if (c !== 20'(ec[i])) begin failures++; $display("FAIL b2b_cum[%0d]: got %0d expected %0d", g[i], c, ec[i]); end
    end
    waitIdle("b2b");
  endtask

  task automatic test_ramp();
    int g[4] = '{0, 63, 100, 255};
    logic [19:0] h, c;
    int start;
    pixQ = {};
    for (int i = 0; i < NB; i++) pixQ.push_back(i);
    start = doneCnt;
    sendFrame(25);
    waitDone(start, "ramp25");
    @(negedge iClk);
    asserts++;
    if (oThresh !== 8'd63) begin failures++; $display("FAIL ramp25_thresh: got %0d expected 63", oThresh); end
    asserts++;
    if (oTotal !== 20'd256) begin failures++; $display("FAIL ramp_total: got %0d expected 256", oTotal); end
    for (int i = 0; i < 4; i++) begin
      readBin(g[i], h, c);
      asserts++;
      if (h !== 20'd1) begin failures++; $display("FAIL ramp_hist[%0d]: got %0d expected 1", g[i], h); end
      asserts++;
      if (c !== 20'(g[i] + 1)) begin failures++; $display("FAIL ramp_cum[%0d]: got %0d expected %0d", g[i], c, g[i] + 1); end
    end
    waitIdle("ramp25");
    start = doneCnt;
    sendFrame(100);
    waitDone(start, "ramp100");
    @(negedge iClk);
    asserts++;
    if (oThresh !== 8'd255) begin failures++; $display("FAIL ramp100_thresh: got %0d expected 255", oThresh); end
    waitIdle("ramp100");
  endtask

  task automatic test_percent_edges();
    int start;
    logic [19:0] h, c;
    int pcts[2] = '{127, 0};
    int ethr[2] = '{9, 0};
    for (int k = 0; k < 2; k++) begin
      pixQ = '{2, 9};
      start = doneCnt;
      sendFrame(pcts[k]);
      waitDone(start, "pct");
      @(negedge iClk);
      asserts++;
      if (oThresh !== 8'(ethr[k])) begin
        failures++;
        $display("FAIL pct%0d_thresh: got %0d expected %0d", pcts[k], oThresh, ethr[k]);
      end
      waitIdle("pct");
    end
    pixQ = {};
    start = doneCnt;
    sendFrame(50);
    waitDone(start, "empty");
    @(negedge iClk);
    asserts++;
    if ({oTotal, oThresh} !== 28'd0) begin
      failures++;
      $display("FAIL empty_total_thresh: got total=%0d thr=%0d expected 0/0", oTotal, oThresh);
    end
    readBin(2, h, c);
    asserts++;
    if (h !== 20'd0) begin failures++; $display("FAIL empty_hist[2]: got %0d expected 0", h); end
    readBin(255, h, c);
    asserts++;
    if (c !== 20'd0) begin failures++; $display("FAIL empty_cum[255]: got %0d expected 0", c); end
    waitIdle("empty");
  endtask

  task automatic test_drop();
    int startDone = doneCnt;
    int startDrop = dropCnt;
    logic [19:0] h, c;
    pixQ = '{10, 10, 10, 10};
    sendFrame(50);
    repeat (10) @(negedge iClk);
    iFvalid = 1'b1;
    iPercent = 7'd50;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      iGray = 8'd20;
      iGrayValid = 1'b1;
    end
    @(negedge iClk);
    iGrayValid = 1'b0;
    @(negedge iClk);
    iFvalid = 1'b0;
    waitDone(startDone, "drop");
    waitIdle("drop");
    asserts++;
    if (dropCnt - startDrop !== 1) begin failures++; $display("FAIL drop_pulse_count: got %0d expected 1", dropCnt - startDrop); end
    asserts++;
    if (doneCnt - startDone !== 1) begin failures++; $display("FAIL drop_done_count: got %0d expected 1", doneCnt - startDone); end
    asserts++;
    if (oTotal !== 20'd4) begin failures++; $display("FAIL drop_total: got %0d expected 4", oTotal); end
    readBin(10, h, c);
    asserts++;
    if (h !== 20'd4) begin failures++; $display("FAIL drop_hist[10]: got %0d expected 4", h); end
    readBin(20, h, c);
    asserts++;
    if (h !== 20'd0) begin failures++; $display("FAIL drop_hist[20]: got %0d expected 0", h); end
    startDone = doneCnt;
    pixQ = '{30, 30, 30};
    sendFrame(50);
    waitDone(startDone, "third");
    @(negedge iClk);
    asserts++;
    if (oTotal !== 20'd3) begin failures++; $display("FAIL third_total: got %0d expected 3", oTotal); end
    readBin(30, h, c);
    asserts++;
    if (h !== 20'd3) begin failures++; $display("FAIL third_hist[30]: got %0d expected 3", h); end
    readBin(10, h, c);
    asserts++;
    if (h !== 20'd0) begin failures++; $display("FAIL third_hist[10]: got %0d expected 0", h); end
    waitIdle("third");
    asserts++;
    if (dropCnt - startDrop !== 1) begin failures++; $display("FAIL third_no_drop: got %0d drops expected 1", dropCnt - startDrop); end
  endtask

  task automatic test_saturation();
    int n = 0;
    while (sBusy && n < 200) begin @(negedge iClk); n++; end
    @(negedge iClk);
    sPercent = 7'd50;
    sFvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      sGray = 4'd3;
      sGrayValid = 1'b1;
    end
    @(negedge iClk);
    sGrayValid = 1'b0;
    @(negedge iClk);
    sFvalid = 1'b0;
    n = 0;
    while (sDone !== 1'b1 && n < 200) begin @(negedge iClk); n++; end
    asserts++;
    if (sDone !== 1'b1) begin failures++; $display("FAIL sat_done_wait: no oDone within %0d cycles", n); end
    @(negedge iClk);
    asserts++;
    if (sTotal !== 4'd15) begin failures++; $display("FAIL sat_total: got %0d expected 15", sTotal); end
    asserts++;
    if (sThresh !== 4'd3) begin failures++; $display("FAIL sat_thresh: got %0d expected 3", sThresh); end
    sReadGray = 4'd3;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    asserts++;
    if (sHisto !== 4'd15) begin failures++; $display("FAIL sat_hist[3]: got %0d expected 15", sHisto); end
    asserts++;
    if (sCumHisto !== 4'd15) begin failures++; $display("FAIL sat_cum[3]: got %0d expected 15", sCumHisto); end
  endtask

  task automatic test_reset_mid_accum();
    int start;
    logic [19:0] h, c;
    @(negedge iClk);
    iPercent = 7'd50;
    iFvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      iGray = 8'd40;
      iGrayValid = 1'b1;
    end
    @(negedge iClk);
    iRst_n = 1'b0;
    iGrayValid = 1'b0;
    iFvalid = 1'b0;
    #1;
    asserts++;
    if ({oGrayHisto, oGrayCumHisto, oTotal, oThresh} !== 68'd0) begin
      failures++;
      $display("FAIL rstmid_data: got h=%0d c=%0d tot=%0d thr=%0d expected all 0",
               oGrayHisto, oGrayCumHisto, oTotal, oThresh);
    end
    asserts++;
    if ({oValid, oDone, oDropped, oBusy} !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_flags: got valid/done/drop/busy=%b expected 0001",
               {oValid, oDone, oDropped, oBusy});
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (NB - 1) @(posedge iClk);
    @(negedge iClk);
    asserts++;
    if (oBusy !== 1'b1) begin failures++; $display("FAIL rstmid_clear_len: busy=%0b after %0d cycles expected 1", oBusy, NB - 1); end
    @(posedge iClk);
    @(negedge iClk);
    asserts++;
    if (oBusy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: busy=%0b after %0d cycles expected 0", oBusy, NB); end
    start = doneCnt;
    pixQ = '{1, 1, 200};
    sendFrame(100);
    waitDone(start, "rstmid");
    @(negedge iClk);
    asserts++;
    if ({oValid, oTotal, oThresh} !== {1'b1, 20'd3, 8'd200}) begin
      failures++;
      $display("FAIL rstmid_frame: got valid=%0b total=%0d thr=%0d expected 1/3/200", oValid, oTotal, oThresh);
    end
    readBin(1, h, c);
    asserts++;
    if ({h, c} !== {20'd2, 20'd2}) begin failures++; $display("FAIL rstmid_bin1: got h=%0d c=%0d expected 2/2", h, c); end
    readBin(40, h, c);
    asserts++;
    if ({h, c} !== {20'd0, 20'd2}) begin failures++; $display("FAIL rstmid_bin40: got h=%0d c=%0d expected 0/2", h, c); end
    waitIdle("rstmid");
  endtask

  initial begin
    test_reset();
    test_single_value();
    test_back_to_back();
    test_ramp();
    test_percent_edges();
    test_drop();
    test_saturation();
    test_reset_mid_accum();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
